// File: rtl/uart_event_tx.sv
// Multi-channel event reporter: rising edges on ev_in queue CODE_BASE+i bytes, sent as UART frames.
// Define UART_EVT_PARITY_EN to add an even-parity bit (11-bit frame); default is 8N1.
module uart_event_tx #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OSR        = 16,
   parameter int unsigned N_CH       = 6,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [7:0]  CODE_BASE  = 8'h41
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [N_CH-1:0]                       ev_in,
   input  logic                                  clr_ovf,
   output logic                                  tx,
   output logic                                  tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_cnt,
   output logic                                  ovf
);

   localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * OSR);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned OW      = (OSR > 1) ? $clog2(OSR) : 1;
   localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_EVT_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [OW-1:0]   os_cnt;
   logic            bit_end;
   logic [7:0]      data;
   logic [2:0]      bit_idx;

   logic [N_CH-1:0] ev_d;
   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] ev_rise;
   logic [N_CH-1:0] grant;
   logic            push;
   logic [7:0]      push_code;
   logic            pop;
   logic            full;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   // Free-running baud tick divider.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt == DW'(DIV - 1)) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         tick    <= 1'b0;
      end
   end

   assign full    = (fifo_cnt == CW'(FIFO_DEPTH));
   assign pop     = (state == S_IDLE) && (fifo_cnt != '0);
   assign bit_end = tick && (os_cnt == OW'(OSR - 1));
   assign tx_busy = (state != S_IDLE);

   // Lowest-index pending channel wins; at most one push per cycle.
   always_comb begin
      ev_rise   = ev_in & ~ev_d;
      grant     = '0;
      push      = 1'b0;
      push_code = '0;
      if (!full) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (pend[i] && !push) begin
               grant[i]  = 1'b1;
               push      = 1'b1;
               push_code = CODE_BASE + 8'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev_d <= '0;
         pend <= '0;
         ovf  <= 1'b0;
      end else begin
         ev_d <= ev_in;
         pend <= (pend & ~grant) | ev_rise;
         if (|(ev_rise & pend & ~grant))
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // tx is updated on the same edge as the state so the line never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         tx      <= 1'b1;
         data    <= '0;
         bit_idx <= '0;
         os_cnt  <= '0;
      end else begin
         if (state != S_IDLE && tick)
            os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
         case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  data   <= mem[rd_ptr];
                  os_cnt <= '0;
                  tx     <= 1'b0;
                  state  <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  bit_idx <= '0;
                  tx      <= data[0];
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
`ifdef UART_EVT_PARITY_EN
                     tx    <= ^data;
                     state <= S_PARITY;
`else
                     tx    <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= data[3'(bit_idx + 3'd1)];
                  end
               end
            end
`ifdef UART_EVT_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  tx    <= 1'b1;
                  state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (bit_end)
                  state <= S_IDLE;
            end
            default: begin
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_event_tx.sv
// Bench for uart_event_tx: directed and random event bursts, frames decoded from the tx line.
// Honours UART_EVT_PARITY_EN for the frame layout.
module tb_uart_event_tx;

   localparam int BIT_CLKS = 160;
   localparam int MID      = 75;
`ifdef UART_EVT_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int BUDGET = 12000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] ev_in = '0;
   logic       clr_ovf = 1'b0;
   logic       tx;
   logic       tx_busy;
   logic [1:0] fifo_cnt;
   logic       ovf;

   int checks = 0;
   int errors = 0;
   int epoch  = 0;

   logic [7:0] rx_q[$];
   logic       ok_q[$];
   logic [7:0] exp_q[$];

   uart_event_tx #(
      .CLK_HZ(1_600_000),
      .BAUD(10_000),
      .OSR(16),
      .N_CH(6),
      .FIFO_DEPTH(2),
      .CODE_BASE(8'h41)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ev_in(ev_in),
      .clr_ovf(clr_ovf),
      .tx(tx),
      .tx_busy(tx_busy),
      .fifo_cnt(fifo_cnt),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Line receiver: samples near the middle of each bit, drops frames cut by a reset.
   initial begin : rx_mon
      logic [7:0] b;
      logic       s_ok;
      int         e0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx === 1'b0) begin
            e0 = epoch;
            repeat (MID) @(negedge clk);
            s_ok = (tx === 1'b0);
            for (int k = 0; k < 8; k++) begin
               repeat (BIT_CLKS) @(negedge clk);
               b[k] = tx;
            end
`ifdef UART_EVT_PARITY_EN
            repeat (BIT_CLKS) @(negedge clk);
            s_ok = s_ok && (tx === ^b);
`endif
            repeat (BIT_CLKS) @(negedge clk);
            s_ok = s_ok && (tx === 1'b1);
            if (epoch == e0) begin
               rx_q.push_back(b);
               ok_q.push_back(s_ok);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_quiet(input string tag);
      int  q;
      logic ok;
      q  = 0;
      ok = 1'b0;
      for (int n = 0; n < BUDGET; n++) begin
         @(negedge clk);
         if (!tx_busy && fifo_cnt == 2'd0) q++;
         else q = 0;
         if (q >= 4) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_quiet"}, 32'(ok), 32'd1);
   endtask

   task automatic model_burst(input logic [5:0] mask);
      for (int i = 0; i < 6; i++)
         if (mask[i]) exp_q.push_back(8'h41 + 8'(i));
   endtask

   task automatic compare_frames(input string tag);
      int n;
      check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
         check($sformatf("%s_frame%0d", tag, i), 32'(ok_q[i]), 32'd1);
      end
      rx_q.delete();
      ok_q.delete();
      exp_q.delete();
   endtask

   task automatic pulse(input logic [5:0] mask, input int hold);
      ev_in = mask;
      repeat (hold) @(negedge clk);
      ev_in = '0;
   endtask

   initial begin
      int   blen;
      logic seen;
      logic [5:0] mask;

      repeat (3) @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(tx_busy), 32'd0);
      check("reset_cnt", 32'(fifo_cnt), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Single event on channel 2: one 0x43 frame, busy for one frame time.
      ev_in = 6'b000100;
      @(negedge clk);
      ev_in = '0;
      blen = 0;
      for (int n = 0; n < 50 && !tx_busy; n++) @(negedge clk);
      for (int n = 0; n < 3000 && tx_busy; n++) begin
         @(negedge clk);
         blen++;
      end
      check("t1_busy_in_range",
            32'(blen >= FRAME_BITS * BIT_CLKS - 9 && blen <= FRAME_BITS * BIT_CLKS), 32'd1);
      model_burst(6'b000100);
      wait_quiet("t1");
      compare_frames("t1");
      check("t1_ovf", 32'(ovf), 32'd0);

      // Simultaneous events on 0, 3, 5.
      pulse(6'b101000 | 6'b000001 | 6'b001000, 2);
      model_burst(6'b101001);
      wait_quiet("t2");
      compare_frames("t2");
      check("t2_ovf", 32'(ovf), 32'd0);

      // All channels at once with a 2-deep FIFO: nothing lost.
      pulse(6'b111111, 3);
      model_burst(6'b111111);
      wait_quiet("t3");
      compare_frames("t3");
      check("t3_ovf", 32'(ovf), 32'd0);

      // Fill the FIFO, then hit channel 1 twice while it is still pending.
      ev_in = 6'b011101;
      repeat (20) @(negedge clk);
      check("t4_full", 32'(fifo_cnt), 32'd2);
      ev_in = 6'b011111;
      repeat (2) @(negedge clk);
      check("t4_first_edge_no_ovf", 32'(ovf), 32'd0);
      ev_in = 6'b011101;
      @(negedge clk);
      ev_in = 6'b011111;
      @(negedge clk);
      check("t4_coalesce_ovf", 32'(ovf), 32'd1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("t4_clr", 32'(ovf), 32'd0);
      ev_in = 6'b011101;
      @(negedge clk);
      ev_in   = 6'b011111;
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("t4_set_beats_clr", 32'(ovf), 32'd1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("t4_clr2", 32'(ovf), 32'd0);
      ev_in = '0;
      // Channel 1 overtakes 4 once space frees; only one 0x42 survives.
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h43);
      exp_q.push_back(8'h44);
      exp_q.push_back(8'h42);
      exp_q.push_back(8'h45);
      wait_quiet("t4");
      compare_frames("t4");

      // Reset in the middle of the data bits with bytes still queued.
      pulse(6'b001110, 2);
      for (int n = 0; n < 50 && !tx_busy; n++) @(negedge clk);
      repeat (400) @(negedge clk);
      #2;
      rst   = 1'b1;
      epoch = epoch + 1;
      #1;
      check("t5_tx", 32'(tx), 32'd1);
      check("t5_busy", 32'(tx_busy), 32'd0);
      check("t5_cnt", 32'(fifo_cnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (3000) begin
         @(negedge clk);
         if (tx_busy) seen = 1'b1;
      end
      check("t5_no_resume", 32'(seen), 32'd0);
      check("t5_no_frames", 32'(rx_q.size()), 32'd0);
      rx_q.delete();
      ok_q.delete();

      // Random bursts checked against the ascending-index model.
      for (int r = 0; r < 5; r++) begin
         mask = 6'($urandom_range(1, 63));
         repeat ($urandom_range(1, 7)) @(negedge clk);
         pulse(mask, $urandom_range(1, 20));
         model_burst(mask);
         wait_quiet($sformatf("rnd%0d", r));
         compare_frames($sformatf("rnd%0d", r));
         check($sformatf("rnd%0d_ovf", r), 32'(ovf), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
